rst_sequencer: RTL and testbench

- Sequences reset release across up to NUM_STAGES downstream domains of the FPGA test top, e.g. stage 0 memory/RAM ctrl, 1 UART, 2 I/O bridge, 3 CPU core.
- Releases stage resets strictly in index order.
- Each release follows a programmable settle delay. The sequencer then waits for that stage's ready acknowledge before moving to the next stage.
- Detects stalled or lost acknowledges, enters a latched fault state, and supports a software-requested full re-sequence.

---
 rtl/rst_sequencer.sv | 136 +++++++++++++
 tb/tb_rst_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Reset sequencer: releases downstream reset domains strictly in index order, each after a
// settle delay and gated on that stage's ready acknowledge, with a latched fault on lost acks.
module rst_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int IDX_W       = 2,
    parameter int CNT_W       = 8,
    parameter int STAGE_DELAY = 8,
    parameter int TIMEOUT     = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [IDX_W-1:0]      fault_stage
);

    typedef enum logic [1:0] {
        ST_DELAY,
        ST_WAIT_READY,
        ST_RUN,
        ST_FAULT
    } state_t;

    // Every output is a flop, so the whole register set travels as one struct.
    typedef struct packed {
        state_t                  state;
        logic [IDX_W-1:0]        idx;
        logic [CNT_W-1:0]        cnt;
        logic [NUM_STAGES-1:0]   stage_rst;
        logic                    busy;
        logic                    done;
        logic                    fault;
        logic [IDX_W-1:0]        fault_stage;
    } regs_t;

    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

    localparam regs_t RESTART = '{
        state:       ST_DELAY,
        idx:         '0,
        cnt:         '0,
        stage_rst:   '1,
        busy:        1'b1,
        done:        1'b0,
        fault:       1'b0,
        fault_stage: '0
    };

    regs_t q;
    regs_t d;

    function automatic regs_t enter_fault(input regs_t r, input logic [IDX_W-1:0] culprit);
        regs_t f = r;
        f.state       = ST_FAULT;
        f.cnt         = '0;
        f.stage_rst   = '1;
        f.busy        = 1'b0;
        f.done        = 1'b0;
        f.fault       = 1'b1;
        f.fault_stage = culprit;
        return f;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_zero(input logic [NUM_STAGES-1:0] v);
        logic [IDX_W-1:0] r = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (!v[k]) r = IDX_W'(k);
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: start from the held value so every path assigns d and no latch is inferred.
        d = q;
        if (soft_rst_req) begin
            d = RESTART;
        end else begin
            unique case (q.state)
                ST_DELAY: begin
                    d.cnt = q.cnt + CNT_W'(1);
                    if (q.cnt == DELAY_LAST) begin
                        d.stage_rst[q.idx] = 1'b0;
                        d.cnt              = '0;
                        d.state            = ST_WAIT_READY;
                    end
                end
                ST_WAIT_READY: begin
                    d.cnt = q.cnt + CNT_W'(1);
                    // A ready seen on the timeout edge still counts as success.
                    if (stage_ready[q.idx]) begin
                        d.cnt = '0;
                        if (q.idx == LAST_IDX) begin
                            d.state = ST_RUN;
                            d.busy  = 1'b0;
                            d.done  = 1'b1;
                        end else begin
                            d.idx   = q.idx + IDX_W'(1);
                            d.state = ST_DELAY;
                        end
                    end else if (q.cnt == TIMEOUT_LAST) begin
                        d = enter_fault(q, q.idx);
                    end
                end
                ST_RUN: begin
                    if (!(&stage_ready)) d = enter_fault(q, lowest_zero(stage_ready));
                end
                ST_FAULT: begin
                    d = q;
                end
            endcase
        end
    end

    // stage_rst comes straight from set-type flops, so async assertion cannot glitch low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESTART;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of d.
            q <= d;
        end
    end

    assign stage_rst   = q.stage_rst;
    assign busy        = q.busy;
    assign done        = q.done;
    assign fault       = q.fault;
    assign fault_stage = q.fault_stage;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: a per-edge reference model built from the release,
// acknowledge, timeout and fault edges of a planned scenario, with randomized ready noise.
module tb_rst_sequencer;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;
    localparam int SD    = 8;
    localparam int TO    = 200;
    localparam int INF   = 1 << 30;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             soft_rst_req = 1'b0;
    logic [N-1:0]     stage_ready = '0;
    logic [N-1:0]     stage_rst;
    logic             busy;
    logic             done;
    logic             fault;
    logic [IDX_W-1:0] fault_stage;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_STAGES (N),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W),
        .STAGE_DELAY(SD),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst_req(soft_rst_req),
        .stage_ready (stage_ready),
        .stage_rst   (stage_rst),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    typedef struct packed {
        logic [N-1:0]     sr;
        logic             busy;
        logic             done;
        logic             fault;
        logic [IDX_W-1:0] fs;
    } outs_t;

    localparam outs_t RESET_OUTS = '{sr: '1, busy: 1'b1, done: 1'b0, fault: 1'b0, fs: '0};

    // Scenario plan; edges are counted from the sequence origin (reset release or soft restart).
    int               w[N];
    int               rel_e[N];
    int               ack_e[N];
    int               done_e;
    int               fault_e;
    int               drop_e;
    logic [N-1:0]     drop_mask;
    logic [IDX_W-1:0] fault_idx;
    bit               noise_en;

    function automatic void set_w(input int a, input int b, input int c, input int e);
        w[0] = a; w[1] = b; w[2] = c; w[3] = e;
    endfunction

    // Stage k releases SD edges after the previous ack; its ready is seen w[k] edges later
    // unless w[k] exceeds TO, in which case the fault lands TO edges after release.
    function automatic void build_plan(input int drop_off);
        int t = SD;
        done_e = INF; fault_e = INF; drop_e = INF; fault_idx = '0;
        for (int k = 0; k < N; k++) begin
            rel_e[k] = INF;
            ack_e[k] = INF;
        end
        for (int k = 0; k < N; k++) begin
            if (fault_e == INF) begin
                rel_e[k] = t;
                if (w[k] <= TO) begin
                    ack_e[k] = t + w[k];
                    t = ack_e[k] + SD;
                end else begin
                    fault_e = t + TO;
                    fault_idx = IDX_W'(k);
                end
            end
        end
        if (fault_e == INF) begin
            done_e = ack_e[N-1];
            if (drop_off > 0 && drop_mask != '0) begin
                drop_e = done_e + drop_off;
                fault_e = drop_e;
                for (int k = N - 1; k >= 0; k--) if (drop_mask[k]) fault_idx = IDX_W'(k);
            end
        end
    endfunction

    function automatic logic [N-1:0] ready_at(input int e);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            if (e > fault_e)         r[k] = 1'($urandom);
            else if (e <= rel_e[k])  r[k] = noise_en ? 1'($urandom) : 1'b1;
            else if (e < ack_e[k])   r[k] = 1'b0;
            else                     r[k] = !(e == drop_e && drop_mask[k]);
        end
        return r;
    endfunction

    function automatic outs_t expect_at(input int e);
        outs_t o;
        o.fs = '0;
        o.fault = 1'b0;
        if (e >= fault_e) begin
            o.sr = '1; o.busy = 1'b0; o.done = 1'b0; o.fault = 1'b1; o.fs = fault_idx;
        end else begin
            for (int k = 0; k < N; k++) o.sr[k] = !(e >= rel_e[k]);
            o.done = (e >= done_e);
            o.busy = !o.done;
        end
        return o;
    endfunction

    task automatic run_plan(input string name, input int first_e, input int last_e, input bit soft_last);
        for (int e = first_e; e <= last_e; e++) begin
            outs_t exp_o;
            outs_t got;
            stage_ready  = ready_at(e);
            soft_rst_req = soft_last && (e == last_e);
            @(posedge clk);
            #1;
            exp_o = soft_rst_req ? RESET_OUTS : expect_at(e);
            got = {stage_rst, busy, done, fault, fault_stage};
            vectors++;
            if (got !== exp_o) begin
                miscompares++;
                $display("FAIL %s edge %0d: got rst=%b b/d/f=%b%b%b fs=%0d, want rst=%b b/d/f=%b%b%b fs=%0d",
                         name, e, got.sr, got.busy, got.done, got.fault, got.fs,
                         exp_o.sr, exp_o.busy, exp_o.done, exp_o.fault, exp_o.fs);
            end
        end
        soft_rst_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({stage_rst, busy, done, fault, fault_stage} !== RESET_OUTS) begin
            miscompares++;
            $display("FAIL reset_state: got %b, want %b",
                     {stage_rst, busy, done, fault, fault_stage}, RESET_OUTS);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_in_order();
        set_w(1, 1, 1, 1); noise_en = 1'b0; drop_mask = '0; build_plan(0);
        run_plan("in_order", 1, 34, 1'b0);
        vectors++;
        if (stage_rst !== 4'b1000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL in_order_e34: got rst=%b busy=%b, want rst=1000 busy=1", stage_rst, busy);
        end
        run_plan("in_order", 35, 35, 1'b0);
        vectors++;
        if (stage_rst !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL in_order_e35: got rst=%b busy=%b done=%b, want 0000 1 0", stage_rst, busy, done);
        end
        run_plan("in_order", 36, 36, 1'b0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL in_order_e36: got done=%b busy=%b, want done=1 busy=0", done, busy);
        end
        run_plan("in_order", 37, 40, 1'b1);
    endtask

    task automatic test_ready_delay();
        set_w(1, 50, 1, 1); noise_en = 1'b1; drop_mask = '0; build_plan(0);
        run_plan("ready_delay", 1, ack_e[1] - 1, 1'b0);
        vectors++;
        if (stage_rst !== 4'b1100 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_delay_hold: got rst=%b fault=%b, want rst=1100 fault=0", stage_rst, fault);
        end
        run_plan("ready_delay", ack_e[1], rel_e[2], 1'b0);
        vectors++;
        if (stage_rst !== 4'b1000) begin
            miscompares++;
            $display("FAIL ready_delay_resume: got rst=%b, want 1000", stage_rst);
        end
        run_plan("ready_delay", rel_e[2] + 1, done_e + 2, 1'b1);
    endtask

    task automatic test_timeout();
        set_w(1, 1, INF, 1); noise_en = 1'b1; drop_mask = '0; build_plan(0);
        run_plan("timeout", 1, rel_e[2] + TO - 1, 1'b0);
        vectors++;
        if (fault !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: got fault=%b busy=%b, want fault=0 busy=1", fault, busy);
        end
        run_plan("timeout", rel_e[2] + TO, rel_e[2] + TO + 3, 1'b0);
        vectors++;
        if (fault !== 1'b1 || fault_stage !== 2'd2 || stage_rst !== 4'b1111 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_fault: got fault=%b fs=%0d rst=%b busy=%b, want 1 2 1111 0",
                     fault, fault_stage, stage_rst, busy);
        end
        run_plan("timeout", rel_e[2] + TO + 4, rel_e[2] + TO + 4, 1'b1);
    endtask

    task automatic test_run_drop();
        set_w(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
              int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
        noise_en = 1'b1; drop_mask = 4'b1010; build_plan(4);
        run_plan("run_drop", 1, drop_e + 2, 1'b0);
        vectors++;
        if (fault !== 1'b1 || fault_stage !== 2'd1 || stage_rst !== 4'b1111) begin
            miscompares++;
            $display("FAIL run_drop_fault: got fault=%b fs=%0d rst=%b, want 1 1 1111", fault, fault_stage, stage_rst);
        end
        run_plan("run_drop", drop_e + 3, drop_e + 3, 1'b1);
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("FAIL run_drop_clear: got fault=%b, want 0", fault);
        end
        set_w(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
              int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
        drop_mask = '0; build_plan(0);
        run_plan("resequence", 1, done_e, 1'b0);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL resequence_done: got done=%b, want 1", done);
        end
        run_plan("resequence", done_e + 1, done_e + 1, 1'b1);
    endtask

    task automatic test_async_reset();
        set_w(1, 1, 40, 1); noise_en = 1'b1; drop_mask = '0; build_plan(0);
        run_plan("async_pre", 1, rel_e[2] + 10, 1'b0);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (stage_rst !== 4'b1111 || busy !== 1'b1 || done !== 1'b0 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL async_assert: got rst=%b busy=%b done=%b fault=%b, want 1111 1 0 0",
                     stage_rst, busy, done, fault);
        end
        @(negedge clk);
        rst = 1'b1;
        set_w(1, 1, 1, 1); noise_en = 1'b0; build_plan(0);
        run_plan("async_post", 1, 36, 1'b0);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL async_post_done: got done=%b, want 1", done);
        end
        run_plan("async_post", 37, 37, 1'b1);
    endtask

    task automatic test_same_edge();
        set_w(1, 1, TO, 1); noise_en = 1'b1; drop_mask = '0; build_plan(0);
        run_plan("ready_on_timeout", 1, done_e, 1'b0);
        vectors++;
        if (fault !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_on_timeout: got fault=%b done=%b, want fault=0 done=1", fault, done);
        end
        run_plan("ready_on_timeout", done_e + 1, done_e + 1, 1'b1);
        set_w(1, 1, 1, 1); noise_en = 1'b0; build_plan(0);
        run_plan("soft_vs_done", 1, 36, 1'b1);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL soft_vs_done: got done=%b busy=%b, want done=0 busy=1", done, busy);
        end
    endtask

    task automatic test_random();
        repeat (12) begin
            int term_e;
            int last_e;
            for (int k = 0; k < N; k++) begin
                int r = int'($urandom_range(0, 9));
                w[k] = (r < 7) ? int'($urandom_range(1, 30)) : (r == 7) ? TO : (r == 8) ? TO + 1 : INF;
            end
            noise_en  = 1'b1;
            drop_mask = N'($urandom_range(1, 15));
            build_plan(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0);
            term_e = (fault_e != INF) ? fault_e : done_e;
            last_e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, term_e))
                                                 : term_e + int'($urandom_range(1, 4));
            run_plan("random", 1, last_e, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_ready_delay();
        test_timeout();
        test_run_drop();
        test_async_reset();
        test_same_edge();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
